uart_rx: RTL and testbench

Asynchronous serial receiver for 8N1 frames at 115200 baud, clocked from the 50 MHz board clock. It is the receive side of the board's UART link. It does the following:
- synchronises the `rx` pin;
- finds and qualifies start bits;
- samples each bit at its centre using a 16x oversampling tick from a phase accumulator;
- presents each received byte on a valid/ready handshake.

Frames with a bad stop bit are flagged and dropped.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the board UART.
// The accumulator increment is common to the receiver and the transmitter rate generator.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OVS          = 16;
    localparam int OVS_MID      = 7;
    localparam int DATA_BITS    = 8;
    localparam int UART_ACC_INC = 2416;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte stream: valid/ready handshake plus the receiver status flags.
// The receiver drives through master; the consumer uses slave.
interface uart_rx_if;

    logic [uart_pkg::DATA_BITS-1:0] data;
    logic                           valid;
    logic                           ready;
    logic                           framing_error;
    logic                           overrun;

    modport master (
        output data, valid, framing_error, overrun,
        input  ready
    );

    modport slave (
        input  data, valid, framing_error, overrun,
        output ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Phase accumulator producing the 16x oversampling tick from its carry-out.
// A synchronous clear re-phases the tick to an accepted start edge.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int OVS_INC   = UART_ACC_INC
) (
    input  logic clock50,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;

    assign sum  = {1'b0, acc} + (ACC_WIDTH + 1)'(OVS_INC);
    assign tick = sum[ACC_WIDTH];

    // NOTE: state uses <= so every flop reads pre-edge values; = would race with other readers.
    always_ff @(posedge clock50) begin
        if (reset || clear) begin
            acc <= '0;
        end else begin
            acc <= sum[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: synchroniser, start qualification, centre sampling on a 16x tick,
// and a valid/ready output with framing-error pulse and sticky overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int OVS_INC   = UART_ACC_INC
) (
    input  logic      clock50,
    input  logic      reset,
    input  logic      rx,
    uart_rx_if.master stream
);

    logic                 rx_meta;
    logic                 rx_s;
    logic [1:0]           settle;
    logic                 armed;
    logic                 tick;
    logic                 start_accept;
    rx_state_t            state;
    logic [3:0]           tcnt;
    logic [2:0]           bitcnt;
    logic [DATA_BITS-1:0] shreg;

    assign start_accept = (state == IDLE) && !rx_s && armed;

    uart_baud_gen #(
        .ACC_WIDTH (ACC_WIDTH),
        .OVS_INC   (OVS_INC)
    ) u_baud_gen (
        .clock50 (clock50),
        .reset   (reset),
        .clear   (start_accept),
        .tick    (tick)
    );

    // A start needs the line seen high once the synchroniser has refilled after reset,
    // so a line held low through reset is never mistaken for a start bit.
    always_ff @(posedge clock50) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            settle  <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            settle  <= {settle[0], 1'b1};
            if (start_accept) begin
                armed <= 1'b0;
            end else if (settle[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            state                <= IDLE;
            tcnt                 <= '0;
            bitcnt               <= '0;
            shreg                <= '0;
            stream.data          <= '0;
            stream.valid         <= 1'b0;
            stream.framing_error <= 1'b0;
            stream.overrun       <= 1'b0;
        end else begin
            stream.framing_error <= 1'b0;
            if (stream.valid && stream.ready) begin
                stream.valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_accept) begin
                        tcnt  <= '0;
                        state <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        if (tcnt == 4'(OVS_MID)) begin
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                tcnt   <= '0;
                                bitcnt <= '0;
                                state  <= DATA;
                            end
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'(OVS - 1)) begin
                            shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'(DATA_BITS - 1)) begin
                                state <= STOP;
                            end
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'(OVS - 1)) begin
                            // A byte landing on a handshake clock replaces the old one without overrun.
                            if (rx_s) begin
                                stream.data  <= shreg;
                                stream.valid <= 1'b1;
                                if (stream.valid && !stream.ready) begin
                                    stream.overrun <= 1'b1;
                                end
                            end else begin
                                stream.framing_error <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed table, hand-written corner sequences,
// and randomised frames against a frame-level reference model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_NS = 8680;

    logic clock50 = 1'b0;
    logic reset   = 1'b1;
    logic rx      = 1'b1;

    uart_rx_if bus ();

    uart_rx dut (
        .clock50 (clock50),
        .reset   (reset),
        .rx      (rx),
        .stream  (bus)
    );

    always #(10ns) clock50 = ~clock50;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int         fe_cycles = 0;
    int         fe_pulses = 0;
    int         xfers     = 0;
    logic [7:0] last_xfer = 8'h00;
    logic       fe_prev   = 1'b0;

    always @(negedge clock50) begin
        if (bus.framing_error === 1'b1) fe_cycles++;
        if (bus.framing_error === 1'b1 && !fe_prev) fe_pulses++;
        fe_prev = (bus.framing_error === 1'b1);
        if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
            xfers++;
            last_xfer = bus.data;
        end
    end

    task automatic set_ready(input logic v);
        @(posedge clock50);
        #1ns;
        bus.ready = v;
    endtask

    task automatic pulse_reset();
        @(posedge clock50);
        #1ns;
        reset = 1'b1;
        @(posedge clock50);
        #1ns;
        reset = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
        @(posedge clock50);
        #3ns;
        rx = 1'b0;
        #(per * 1ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(per * 1ns);
        end
        rx = stop;
        #(per * 1ns);
        rx = 1'b1;
    endtask

    task automatic settle_out();
        repeat (20) @(negedge clock50);
    endtask

    task automatic drain(input string name);
        set_ready(1'b1);
        set_ready(1'b0);
        @(negedge clock50);
        check(name, 32'(bus.valid), 32'd0);
    endtask

    typedef struct {
        logic [7:0] byte_v;
        int         per;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_fe;
        logic       do_drain;
    } vec_t;

    vec_t vecs[3];

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: time limit reached before the test ended");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int         x0, f0, c0;
        logic [7:0] m_data;
        logic       m_valid, m_overrun;

        vecs[0] = '{8'h96, 8854, 1'b1, 8'h96, 1'b1, 0, 1'b1};
        vecs[1] = '{8'h96, 8506, 1'b1, 8'h96, 1'b1, 0, 1'b0};
        vecs[2] = '{8'hFF, 8680, 1'b0, 8'h96, 1'b1, 1, 1'b1};

        bus.ready = 1'b0;
        repeat (4) @(posedge clock50);
        #1ns;
        reset = 1'b0;
        @(negedge clock50);
        check("rst_data", 32'(bus.data), 32'h00);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_fe", 32'(bus.framing_error), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        repeat (10) @(negedge clock50);

        // Single byte, ready held high.
        set_ready(1'b1);
        x0 = xfers; f0 = fe_pulses;
        send_frame(8'h40, BIT_NS, 1'b1);
        settle_out();
        check("single_xfers", 32'(xfers - x0), 32'd1);
        check("single_data", 32'(last_xfer), 32'h40);
        check("single_fe", 32'(fe_pulses - f0), 32'd0);
        check("single_valid_after", 32'(bus.valid), 32'd0);
        set_ready(1'b0);

        // Table: baud tolerance and framing error.
        for (int i = 0; i < 3; i++) begin
            f0 = fe_pulses; c0 = fe_cycles;
            send_frame(vecs[i].byte_v, vecs[i].per, vecs[i].stop);
            settle_out();
            check($sformatf("vec%0d_data", i), 32'(bus.data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_fe_pulses", i), 32'(fe_pulses - f0), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d_fe_width", i), 32'(fe_cycles - c0), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d_overrun", i), 32'(bus.overrun), 32'd0);
            if (vecs[i].do_drain) drain($sformatf("vec%0d_drain", i));
        end

        // Back-to-back with backpressure.
        send_frame(8'h55, BIT_NS, 1'b1);
        check("b2b_first_data", 32'(bus.data), 32'h55);
        check("b2b_first_valid", 32'(bus.valid), 32'd1);
        check("b2b_first_overrun", 32'(bus.overrun), 32'd0);
        send_frame(8'hA3, BIT_NS, 1'b1);
        settle_out();
        check("b2b_second_data", 32'(bus.data), 32'hA3);
        check("b2b_second_valid", 32'(bus.valid), 32'd1);
        check("b2b_overrun", 32'(bus.overrun), 32'd1);
        drain("b2b_drain");
        check("b2b_overrun_sticky", 32'(bus.overrun), 32'd1);

        // Glitch shorter than half a bit.
        x0 = xfers; f0 = fe_pulses;
        @(posedge clock50);
        #3ns;
        rx = 1'b0;
        #2000ns;
        rx = 1'b1;
        #(BIT_NS * 3 * 1ns / 2);
        @(negedge clock50);
        check("glitch_valid", 32'(bus.valid), 32'd0);
        check("glitch_fe", 32'(fe_pulses - f0), 32'd0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        send_frame(8'h3C, BIT_NS, 1'b1);
        settle_out();
        check("glitch_next_data", 32'(bus.data), 32'h3C);
        check("glitch_next_valid", 32'(bus.valid), 32'd1);
        drain("glitch_drain");

        // Reset during data bit 4.
        x0 = xfers; f0 = fe_pulses;
        fork
            send_frame(8'h81, BIT_NS, 1'b1);
            begin
                #(BIT_NS * 11 * 1ns / 2);
                pulse_reset();
                @(negedge clock50);
                check("midrst_data", 32'(bus.data), 32'h00);
                check("midrst_valid", 32'(bus.valid), 32'd0);
                check("midrst_fe", 32'(bus.framing_error), 32'd0);
                check("midrst_overrun", 32'(bus.overrun), 32'd0);
            end
        join
        settle_out();
        #(BIT_NS * 5 * 1ns);
        check("midrst_no_valid", 32'(bus.valid), 32'd0);
        check("midrst_no_fe", 32'(fe_pulses - f0), 32'd0);
        send_frame(8'h12, BIT_NS, 1'b1);
        settle_out();
        check("midrst_next_data", 32'(bus.data), 32'h12);
        check("midrst_next_valid", 32'(bus.valid), 32'd1);
        drain("midrst_drain");

        // Randomised frames against the frame-level model.
        m_data = 8'h12; m_valid = 1'b0; m_overrun = 1'b0;
        for (int r = 0; r < 4; r++) begin
            logic [7:0] b, exp_last;
            int         per, exp_x, exp_fe;
            logic       stop, rdy;
            b    = 8'($urandom);
            per  = 8506 + int'($urandom_range(0, 348));
            stop = ($urandom_range(0, 3) != 0);
            rdy  = 1'($urandom_range(0, 1));
            exp_x = 0; exp_last = 8'h00;
            if (rdy && m_valid) begin
                exp_x++;
                exp_last = m_data;
                m_valid  = 1'b0;
            end
            if (stop) begin
                if (!rdy && m_valid) m_overrun = 1'b1;
                m_data = b;
                if (rdy) begin
                    exp_x++;
                    exp_last = b;
                end else begin
                    m_valid = 1'b1;
                end
                exp_fe = 0;
            end else begin
                exp_fe = 1;
            end
            x0 = xfers; f0 = fe_pulses;
            set_ready(rdy);
            send_frame(b, per, stop);
            settle_out();
            check($sformatf("rnd%0d_data", r), 32'(bus.data), 32'(m_data));
            check($sformatf("rnd%0d_valid", r), 32'(bus.valid), 32'(m_valid));
            check($sformatf("rnd%0d_overrun", r), 32'(bus.overrun), 32'(m_overrun));
            check($sformatf("rnd%0d_xfers", r), 32'(xfers - x0), 32'(exp_x));
            check($sformatf("rnd%0d_fe", r), 32'(fe_pulses - f0), 32'(exp_fe));
            if (exp_x > 0) check($sformatf("rnd%0d_last", r), 32'(last_xfer), 32'(exp_last));
            set_ready(1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
